// File: rtl/lfsr_stream_decryptor.sv
// Receive-side stream decryptor: framed ciphertext bytes are XORed with an 8-bit LFSR keystream
// that reseeds on start-of-frame and advances only on bytes that are loaded into the output register.
module lfsr_stream_decryptor #(
  parameter logic [7:0] DEFAULT_SEED = 8'hAA,
  parameter int         MAX_LEN      = 64,
  parameter int         LEN_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       key_seed,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_sof,
  input  logic             s_eof,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_sof,
  output logic             m_eof,
  output logic             frame_done,
  output logic [LEN_W-1:0] frame_len,
  output logic             err_nosof,
  output logic             err_resync,
  output logic             err_overlen,
  output logic             state_dbg
);

  // Handshake: a byte moves on either side only when valid and ready are both high in the
  // same cycle; s_ready depends only on the output register state and m_ready.

  typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  state_t           state;
  logic [7:0]       lfsr;
  logic [LEN_W-1:0] len;

  logic             accept;
  logic             load;
  logic [7:0]       seed;
  logic [7:0]       key;
  logic [LEN_W-1:0] new_len;
  logic             hit_max;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  assign s_ready   = !m_valid || m_ready;
  assign state_dbg = (state == FRAME);

  always_comb begin
    accept  = s_valid && s_ready;
    // A zero seed would lock the LFSR at zero forever.
    seed    = (key_seed == 8'h00) ? DEFAULT_SEED : key_seed;
    key     = s_sof ? seed : lfsr;
    new_len = s_sof ? LEN_W'(1) : len + LEN_W'(1);
    hit_max = (new_len == MAX_LEN_V);
    load    = accept && (s_sof || state == FRAME);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lfsr        <= DEFAULT_SEED;
      len         <= '0;
      m_valid     <= 1'b0;
      m_data      <= 8'h00;
      m_sof       <= 1'b0;
      m_eof       <= 1'b0;
      frame_done  <= 1'b0;
      frame_len   <= '0;
      err_nosof   <= 1'b0;
      err_resync  <= 1'b0;
      err_overlen <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      err_nosof   <= 1'b0;
      err_resync  <= 1'b0;
      err_overlen <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (load) begin
        m_valid    <= 1'b1;
        m_data     <= s_data ^ key;
        m_sof      <= s_sof;
        lfsr       <= lfsr_step(key);
        len        <= new_len;
        err_resync <= s_sof && (state == FRAME);
        if (s_eof || hit_max) begin
          // Overlength closes the frame as if eof had arrived on this byte.
          m_eof       <= 1'b1;
          frame_done  <= 1'b1;
          frame_len   <= new_len;
          err_overlen <= !s_eof;
          state       <= IDLE;
        end else begin
          m_eof <= 1'b0;
          state <= FRAME;
        end
      end else if (accept) begin
        err_nosof <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream_decryptor.sv
// Directed bench for lfsr_stream_decryptor: expected plaintext bytes and pulses are queued as
// stimulus is issued and checked by a monitor on the first cycle each byte appears.
module tb_lfsr_stream_decryptor;

  localparam int MAX_LEN = 4;
  localparam int LEN_W   = 8;

  logic             clk;
  logic             reset;
  logic [7:0]       key_seed;
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_data;
  logic             s_sof;
  logic             s_eof;
  logic             m_valid;
  logic             m_ready;
  logic [7:0]       m_data;
  logic             m_sof;
  logic             m_eof;
  logic             frame_done;
  logic [LEN_W-1:0] frame_len;
  logic             err_nosof;
  logic             err_resync;
  logic             err_overlen;
  logic             state_dbg;

  int vectors;
  int miscompares;
  int nosof_cnt;
  int ready_mode;
  logic [7:0]  last_len;
  logic [20:0] exp_q[$];

  lfsr_stream_decryptor #(
    .DEFAULT_SEED(8'hAA),
    .MAX_LEN     (MAX_LEN),
    .LEN_W       (LEN_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_seed   (key_seed),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_sof      (s_sof),
    .s_eof      (s_eof),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_sof      (m_sof),
    .m_eof      (m_eof),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .err_nosof  (err_nosof),
    .err_resync (err_resync),
    .err_overlen(err_overlen),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downstream ready pattern: 0 always ready, 1 toggling, 2 held low
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'b0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // expected byte {data, sof, eof, frame_done, err_resync, err_overlen, frame_len}
  task automatic push(input logic [7:0] d, input logic sof, input logic eof, input logic done,
                      input logic resync, input logic overlen, input logic [7:0] flen);
    if (done) last_len = flen;
    exp_q.push_back({d, sof, eof, done, resync, overlen, last_len});
  endtask

  // called at posedge+1; returns at posedge+1 after the byte was accepted
  task automatic send(input logic [7:0] d, input logic sof, input logic eof, input logic [7:0] seed);
    logic acc;
    s_valid  = 1'b1;
    s_data   = d;
    s_sof    = sof;
    s_eof    = eof;
    key_seed = seed;
    acc      = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got no s_ready expected accept of %h", d);
    end
    s_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d bytes outstanding expected 0", exp_q.size());
    end
    gap(2);
  endtask

  // scoreboard monitor
  initial begin
    logic        prev_stall;
    logic [9:0]  prev_out;
    logic [20:0] e;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (m_valid && !prev_stall) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL out_unexpected: got byte %h expected no output", m_data);
          end else begin
            e = exp_q.pop_front();
            check("out_byte", {11'd0, m_data, m_sof, m_eof, frame_done, err_resync, err_overlen, frame_len},
                  {11'd0, e});
          end
        end else begin
          if (frame_done || err_resync || err_overlen) begin
            vectors++;
            miscompares++;
            $display("FAIL stray_pulse: got done/resync/overlen %b%b%b expected 000",
                     frame_done, err_resync, err_overlen);
          end
          if (prev_stall && m_valid && {m_data, m_sof, m_eof} !== prev_out) begin
            vectors++;
            miscompares++;
            $display("FAIL stall_hold: got %h expected %h", {m_data, m_sof, m_eof}, prev_out);
          end
        end
        if (err_nosof) nosof_cnt++;
        prev_stall = m_valid && !m_ready;
        prev_out   = {m_data, m_sof, m_eof};
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    nosof_cnt   = 0;
    ready_mode  = 0;
    last_len    = 8'h00;
    reset       = 1'b1;
    s_valid     = 1'b0;
    s_data      = 8'h00;
    s_sof       = 1'b0;
    s_eof       = 1'b0;
    key_seed    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", {9'd0, m_valid, m_data, m_sof, m_eof, frame_done, frame_len,
                          err_nosof, err_resync, err_overlen, state_dbg, s_ready}, 32'h1);
    @(posedge clk);
    #1;

    // 1: default seed frame
    push(8'h68, 1, 0, 0, 0, 0, 0);
    push(8'h65, 0, 0, 0, 0, 0, 0);
    push(8'h6C, 0, 1, 1, 0, 0, 3);
    send(8'hC2, 1, 0, 8'h00);
    send(8'h30, 0, 0, 8'h00);
    send(8'hC7, 0, 1, 8'h00);
    drain();

    // explicit seed 01: keystream 01,02
    push(8'h01, 1, 0, 0, 0, 0, 0);
    push(8'h02, 0, 1, 1, 0, 0, 2);
    send(8'h00, 1, 0, 8'h01);
    send(8'h00, 0, 1, 8'h55);
    drain();

    // 2: same frame with toggling ready and input gaps
    ready_mode = 1;
    push(8'h68, 1, 0, 0, 0, 0, 0);
    push(8'h65, 0, 0, 0, 0, 0, 0);
    push(8'h6C, 0, 1, 1, 0, 0, 3);
    send(8'hC2, 1, 0, 8'h00);
    gap(2);
    send(8'h30, 0, 0, 8'h00);
    gap(1);
    send(8'hC7, 0, 1, 8'h00);
    drain();
    ready_mode = 0;
    gap(1);

    // 3: bytes without sof in IDLE are dropped
    nosof_cnt = 0;
    send(8'h11, 0, 0, 8'h00);
    send(8'h22, 0, 0, 8'h00);
    gap(3);
    check("nosof_count_idle", nosof_cnt, 2);
    push(8'h00, 1, 1, 1, 0, 0, 1);
    send(8'hAA, 1, 1, 8'h00);
    drain();

    // 4: mid-frame sof restarts the keystream
    push(8'h68, 1, 0, 0, 0, 0, 0);
    push(8'h65, 0, 0, 0, 0, 0, 0);
    push(8'h68, 1, 0, 0, 1, 0, 0);
    push(8'h65, 0, 0, 0, 0, 0, 0);
    push(8'h6C, 0, 1, 1, 0, 0, 3);
    send(8'hC2, 1, 0, 8'h00);
    send(8'h30, 0, 0, 8'h00);
    send(8'hC2, 1, 0, 8'h00);
    send(8'h30, 0, 0, 8'h00);
    send(8'hC7, 0, 1, 8'h00);
    drain();

    // 5: overlength at MAX_LEN=4, keystream AA,55,AB,57
    nosof_cnt = 0;
    push(8'hAA, 1, 0, 0, 0, 0, 0);
    push(8'h55, 0, 0, 0, 0, 0, 0);
    push(8'hAB, 0, 0, 0, 0, 0, 0);
    push(8'h57, 0, 1, 1, 0, 1, 4);
    send(8'h00, 1, 0, 8'h00);
    send(8'h00, 0, 0, 8'h00);
    send(8'h00, 0, 0, 8'h00);
    send(8'h00, 0, 0, 8'h00);
    send(8'h01, 0, 0, 8'h00);
    send(8'h02, 0, 0, 8'h00);
    drain();
    check("nosof_count_overlen", nosof_cnt, 2);
    check("state_after_overlen", {31'd0, state_dbg}, 0);

    // 6: reset while a byte is stalled mid-frame
    ready_mode = 2;
    gap(2);
    push(8'h68, 1, 0, 0, 0, 0, 0);
    send(8'hC2, 1, 0, 8'h00);
    @(negedge clk);
    check("stalled_valid", {30'd0, m_valid, state_dbg}, 32'h3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_midframe", {22'd0, m_valid, state_dbg, frame_len}, 0);
    last_len = 8'h00;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    ready_mode = 0;
    gap(1);
    push(8'h68, 1, 1, 1, 0, 0, 1);
    send(8'hC2, 1, 1, 8'h00);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
